// File: rtl/pio_pkg.sv
// Shared definitions for the PIO shift controller: FSM states, decoded op codes
// and the 5-bit threshold helper where 0 stands for a full 32-bit word.
package pio_pkg;

  localparam int PIO_W = 32;

  typedef enum logic [1:0] {
    ST_RUN       = 2'd0,
    ST_WAIT_PULL = 2'd1,
    ST_WAIT_PUSH = 2'd2
  } state_t;

  typedef enum logic [2:0] {
    OP_NONE = 3'd0,
    OP_PULL = 3'd1,
    OP_PUSH = 3'd2,
    OP_OUT  = 3'd3,
    OP_IN   = 3'd4
  } op_t;

  function automatic logic [5:0] th_to_bits(input logic [4:0] th);
    return (th == 5'd0) ? 6'd32 : {1'b0, th};
  endfunction

endpackage

// File: rtl/pio_autopush_track.sv
// Remembers that an IN filled the ISR up to the autopush threshold so the push
// happens on the following enabled cycle; cleared by any completed push.
module pio_autopush_track
  import pio_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic       cfg_autopush,
  input  logic [4:0] cfg_push_th,
  input  logic [5:0] isr_count,
  input  logic       in_fire,
  input  logic [4:0] in_bits,
  input  logic       push_done,
  output logic       pending
);

  logic       pending_q, pending_d;
  logic [6:0] fill_sum;
  logic       reached;

  // 7-bit sum so a full ISR plus a 32-bit IN cannot wrap below the threshold
  assign fill_sum = {1'b0, isr_count} + {1'b0, th_to_bits(in_bits)};
  assign reached  = fill_sum >= {1'b0, th_to_bits(cfg_push_th)};

  always_comb begin
    pending_d = pending_q;
    if (in_fire && cfg_autopush && reached) pending_d = 1'b1;
    else if (push_done)                     pending_d = 1'b0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) pending_q <= 1'b0;
    else          pending_q <= pending_d;
  end

  assign pending = pending_q;

endmodule

// File: rtl/pio_shift_ctrl.sv
// OSR/ISR sequencer: PULL/PUSH/OUT/IN, autopull refill and autopush, with stall on FIFO blocking.
// Define PIO_AUTOPULL_PREFETCH_EN to refill an exhausted OSR in the background on idle cycles.
module pio_shift_ctrl
  import pio_pkg::*;
#(
  parameter int W = PIO_W
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         penable,
  input  logic         op_pull,
  input  logic         op_push,
  input  logic         op_out,
  input  logic         op_in,
  input  logic         op_block,
  input  logic         op_ifx,
  input  logic [4:0]   op_bits,
  input  logic [W-1:0] x_data,
  input  logic         cfg_autopull,
  input  logic         cfg_autopush,
  input  logic [4:0]   cfg_pull_th,
  input  logic [4:0]   cfg_push_th,
  input  logic [5:0]   osr_count,
  input  logic [5:0]   isr_count,
  input  logic [W-1:0] isr_data,
  input  logic         tx_valid,
  input  logic [W-1:0] tx_data,
  output logic         tx_ready,
  input  logic         rx_ready,
  output logic         rx_valid,
  output logic [W-1:0] rx_data,
  output logic         osr_set,
  output logic [W-1:0] osr_din,
  output logic [5:0]   osr_bits,
  output logic         osr_shift_en,
  output logic         isr_set,
  output logic         isr_shift_en,
  output logic [4:0]   shift_amt,
  output logic         stall,
  output logic [1:0]   dbg_state
);

  // Handshakes: tx_ready pops the TX head and rx_valid pushes rx_data, each in the
  // single enabled cycle it is high; the FIFO side must honour both without delay.
  state_t     state_q, state_d;
  op_t        op;
  logic       active, push_pending;
  logic [5:0] pull_th_bits, push_th_bits;
  logic       osr_refill, pull_skip, push_skip;

  always_comb begin
    op = OP_NONE;
    if      (op_pull) op = OP_PULL;
    else if (op_push) op = OP_PUSH;
    else if (op_out)  op = OP_OUT;
    else if (op_in)   op = OP_IN;
  end

  // Reset gates the outputs so an asserted reset_n silences every strobe at once
  assign active       = penable && reset_n;
  assign pull_th_bits = th_to_bits(cfg_pull_th);
  assign push_th_bits = th_to_bits(cfg_push_th);
  assign osr_refill   = cfg_autopull && (osr_count >= pull_th_bits);
  assign pull_skip    = op_ifx && cfg_autopull && (osr_count < pull_th_bits);
  assign push_skip    = op_ifx && (isr_count < push_th_bits);
  assign osr_bits     = 6'd0;

  always_comb begin
    state_d      = state_q;
    stall        = 1'b0;
    tx_ready     = 1'b0;
    rx_valid     = 1'b0;
    rx_data      = '0;
    osr_set      = 1'b0;
    osr_din      = '0;
    osr_shift_en = 1'b0;
    isr_set      = 1'b0;
    isr_shift_en = 1'b0;
    shift_amt    = 5'd0;
    if (active) begin
      unique case (state_q)
        ST_RUN: begin
          if (push_pending && !rx_ready) begin
            stall   = 1'b1;
            state_d = ST_WAIT_PUSH;
          end else begin
            if (push_pending) begin
              rx_valid = 1'b1;
              rx_data  = isr_data;
              isr_set  = 1'b1;
            end
            unique case (op)
              OP_PULL: begin
                if (!pull_skip) begin
                  if (tx_valid) begin
                    tx_ready = 1'b1;
                    osr_set  = 1'b1;
                    osr_din  = tx_data;
                  end else if (op_block) begin
                    stall   = 1'b1;
                    state_d = ST_WAIT_PULL;
                  end else begin
                    osr_set = 1'b1;
                    osr_din = x_data;
                  end
                end
              end
              OP_PUSH: begin
                if (push_pending) begin
                  stall = 1'b1;
                end else if (!push_skip) begin
                  if (rx_ready) begin
                    rx_valid = 1'b1;
                    rx_data  = isr_data;
                    isr_set  = 1'b1;
                  end else if (op_block) begin
                    stall   = 1'b1;
                    state_d = ST_WAIT_PUSH;
                  end
                end
              end
              OP_OUT: begin
                // Exhausted OSR: refill first and let the OUT re-issue on the fresh word
                if (osr_refill) begin
                  stall = 1'b1;
                  if (tx_valid) begin
                    tx_ready = 1'b1;
                    osr_set  = 1'b1;
                    osr_din  = tx_data;
                  end else begin
                    state_d = ST_WAIT_PULL;
                  end
                end else begin
                  osr_shift_en = 1'b1;
                  shift_amt    = op_bits;
                end
              end
              OP_IN: begin
                if (push_pending) begin
                  stall = 1'b1;
                end else begin
                  isr_shift_en = 1'b1;
                  shift_amt    = op_bits;
                end
              end
              default: begin
`ifdef PIO_AUTOPULL_PREFETCH_EN
                if (osr_refill && tx_valid) begin
                  tx_ready = 1'b1;
                  osr_set  = 1'b1;
                  osr_din  = tx_data;
                end
`endif
              end
            endcase
          end
        end
        ST_WAIT_PULL: begin
          stall = 1'b1;
          if (tx_valid) begin
            tx_ready = 1'b1;
            osr_set  = 1'b1;
            osr_din  = tx_data;
            stall    = op_out;
            state_d  = ST_RUN;
          end
        end
        ST_WAIT_PUSH: begin
          stall = 1'b1;
          if (rx_ready) begin
            rx_valid = 1'b1;
            rx_data  = isr_data;
            isr_set  = 1'b1;
            stall    = push_pending && (op_in || op_push);
            state_d  = ST_RUN;
          end
        end
        default: state_d = ST_RUN;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)     state_q <= ST_RUN;
    else if (penable) state_q <= state_d;
  end

  assign dbg_state = state_q;

  pio_autopush_track u_autopush_track (
    .clk          (clk),
    .reset_n      (reset_n),
    .cfg_autopush (cfg_autopush),
    .cfg_push_th  (cfg_push_th),
    .isr_count    (isr_count),
    .in_fire      (isr_shift_en),
    .in_bits      (op_bits),
    .push_done    (isr_set),
    .pending      (push_pending)
  );

endmodule
